// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: bus encodings, slave state encoding and legality checks.
// Used by ahb_slave_chk and ahb_slave_if.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        SLV_IDLE,
        SLV_ACCESS,
        SLV_ERR1,
        SLV_ERR2
    } slv_state_e;

    // A transfer may not be wider than the data bus.
    function automatic logic size_ok(input logic [2:0] size, input int dataWidth);
        int bits;
        bits = 8 << size;
        return bits <= dataWidth;
    endfunction

    // Seven low address bits cover the largest encodable size (128 bytes).
    function automatic logic is_aligned(input logic [6:0] addrLow, input logic [2:0] size);
        logic [7:0] mask;
        mask = (8'd1 << size) - 8'd1;
        return ({1'b0, addrLow} & mask) == 8'd0;
    endfunction

endpackage

// File: rtl/ahb_slave_chk.sv
// Combinational size/alignment check and (with AHB_SLV_WSTRB_EN) byte-lane strobe
// generation for one address phase.
module ahb_slave_chk
    import ahb_pkg::*;
#(
    parameter int AHB_DATA_WIDTH = 32
)
(
    input  logic [6:0]                  addrLow_i,
    input  logic [2:0]                  size_i,
    output logic                        sizeOk_o,
    output logic                        aligned_o
`ifdef AHB_SLV_WSTRB_EN
    ,
    output logic [AHB_DATA_WIDTH/8-1:0] strb_o
`endif
);

    localparam int BYTES = AHB_DATA_WIDTH / 8;

    assign sizeOk_o  = size_ok(size_i, AHB_DATA_WIDTH);
    assign aligned_o = is_aligned(addrLow_i, size_i);

`ifdef AHB_SLV_WSTRB_EN
    // Lanes from the byte offset within the bus word up to offset + transfer bytes.
    always_comb begin
        int offset;
        int nBytes;
        offset = int'(addrLow_i) % BYTES;
        nBytes = 1 << size_i;
        strb_o = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (b >= offset && b < offset + nBytes) begin
                strb_o[b] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave interface: captures address phases and hands one valid/ready beat per
// legal transfer to a backend. Optional byte strobes enabled by defining AHB_SLV_WSTRB_EN.
module ahb_slave_if
    import ahb_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
)
(
    input  logic                        ahb_clk_in,
    input  logic                        ahb_rst_in,
    input  logic                        ahb_sel_in,
    input  logic [AHB_ADDR_WIDTH-1:0]   ahb_addr_in,
    input  logic [1:0]                  ahb_trans_in,
    input  logic [2:0]                  ahb_burst_in,
    input  logic [2:0]                  ahb_size_in,
    input  logic                        ahb_write_in,
    input  logic [AHB_DATA_WIDTH-1:0]   ahb_wdata_in,
    input  logic                        ahb_ready_in,
    output logic                        ahb_ready_out,
    output logic                        ahb_resp_out,
    output logic [AHB_DATA_WIDTH-1:0]   ahb_rdata_out,
    output logic                        other_valid_out,
    output logic [AHB_ADDR_WIDTH-1:0]   other_addr_out,
    output logic [2:0]                  other_size_out,
    output logic                        other_write_out,
    output logic [AHB_DATA_WIDTH-1:0]   other_wdata_out,
`ifdef AHB_SLV_WSTRB_EN
    output logic [AHB_DATA_WIDTH/8-1:0] other_strb_out,
`endif
    input  logic                        other_ready_in,
    input  logic                        other_error_in,
    input  logic [AHB_DATA_WIDTH-1:0]   other_rdata_in
);

    slv_state_e                state_q, state_d;
    logic [AHB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]                size_q, size_d;
    logic                      write_q, write_d;
    logic                      accept;
    logic                      capture;
    logic                      sizeOk;
    logic                      aligned;
    logic                      unusedBits;

`ifdef AHB_SLV_WSTRB_EN
    logic [AHB_DATA_WIDTH/8-1:0] strb_q, strb_d, strbNext;
`endif

    // Burst type and the BUSY/SEQ distinction carry no meaning for a single-beat slave.
    assign unusedBits = ^{ahb_burst_in, ahb_trans_in[0]};

    assign accept = ahb_sel_in && ahb_ready_in && ahb_trans_in[1];

    ahb_slave_chk #(
        .AHB_DATA_WIDTH (AHB_DATA_WIDTH)
    ) u_chk (
        .addrLow_i (ahb_addr_in[6:0]),
        .size_i    (ahb_size_in),
        .sizeOk_o  (sizeOk),
        .aligned_o (aligned)
`ifdef AHB_SLV_WSTRB_EN
        ,
        .strb_o    (strbNext)
`endif
    );

    always_ff @(posedge ahb_clk_in) begin
        if (ahb_rst_in) begin
            state_q <= SLV_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
`ifdef AHB_SLV_WSTRB_EN
            strb_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
`ifdef AHB_SLV_WSTRB_EN
            strb_q  <= strb_d;
`endif
        end
    end

    // A new address phase is only taken when the current data phase is finishing cleanly.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        size_d          = size_q;
        write_d         = write_q;
`ifdef AHB_SLV_WSTRB_EN
        strb_d          = strb_q;
`endif
        capture         = 1'b0;
        ahb_ready_out   = 1'b1;
        ahb_resp_out    = HRESP_OKAY;
        other_valid_out = 1'b0;
        ahb_rdata_out   = '0;

        case (state_q)
            SLV_IDLE: begin
                capture = accept;
            end
            SLV_ACCESS: begin
                other_valid_out = 1'b1;
                if (!other_ready_in) begin
                    ahb_ready_out = 1'b0;
                end else if (other_error_in) begin
                    ahb_ready_out = 1'b0;
                    ahb_resp_out  = HRESP_ERROR;
                    state_d       = SLV_ERR2;
                end else begin
                    ahb_rdata_out = write_q ? '0 : other_rdata_in;
                    capture       = accept;
                    state_d       = SLV_IDLE;
                end
            end
            SLV_ERR1: begin
                ahb_ready_out = 1'b0;
                ahb_resp_out  = HRESP_ERROR;
                state_d       = SLV_ERR2;
            end
            SLV_ERR2: begin
                ahb_resp_out = HRESP_ERROR;
                capture      = accept;
                state_d      = SLV_IDLE;
            end
            default: begin
                state_d = SLV_IDLE;
            end
        endcase

        if (capture) begin
            addr_d  = ahb_addr_in;
            size_d  = ahb_size_in;
            write_d = ahb_write_in;
`ifdef AHB_SLV_WSTRB_EN
            strb_d  = strbNext;
`endif
            state_d = (sizeOk && aligned) ? SLV_ACCESS : SLV_ERR1;
        end

        // Reset overrides a completing beat in the same cycle.
        if (ahb_rst_in) begin
            ahb_ready_out   = 1'b1;
            ahb_resp_out    = HRESP_OKAY;
            other_valid_out = 1'b0;
            ahb_rdata_out   = '0;
        end
    end

    assign other_addr_out  = addr_q;
    assign other_size_out  = size_q;
    assign other_write_out = write_q;
    assign other_wdata_out = ahb_wdata_in;

`ifdef AHB_SLV_WSTRB_EN
    assign other_strb_out = other_valid_out ? strb_q : '0;
`endif

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: a scoreboard of expected backend beats is filled
// when address phases are driven and drained when beats complete.
module tb_ahb_slave_if;

    import ahb_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
    } beat_t;

    logic        ahb_clk_in = 1'b0;
    logic        ahb_rst_in;
    logic        ahb_sel_in;
    logic [31:0] ahb_addr_in;
    logic [1:0]  ahb_trans_in;
    logic [2:0]  ahb_burst_in;
    logic [2:0]  ahb_size_in;
    logic        ahb_write_in;
    logic [31:0] ahb_wdata_in;
    logic        ahb_ready_in;
    logic        ahb_ready_out;
    logic        ahb_resp_out;
    logic [31:0] ahb_rdata_out;
    logic        other_valid_out;
    logic [31:0] other_addr_out;
    logic [2:0]  other_size_out;
    logic        other_write_out;
    logic [31:0] other_wdata_out;
    logic        other_ready_in;
    logic        other_error_in;
    logic [31:0] other_rdata_in;
`ifdef AHB_SLV_WSTRB_EN
    logic [3:0]  other_strb_out;
`endif

    int    testsRun    = 0;
    int    testsFailed = 0;
    beat_t sbQ[$];
    beat_t exp;

    // Single-slave bus: the mux returns this slave's own HREADYOUT.
    assign ahb_ready_in = ahb_ready_out;

    always #5 ahb_clk_in = ~ahb_clk_in;

    ahb_slave_if #(
        .AHB_ADDR_WIDTH (32),
        .AHB_DATA_WIDTH (32)
    ) dut (
        .ahb_clk_in      (ahb_clk_in),
        .ahb_rst_in      (ahb_rst_in),
        .ahb_sel_in      (ahb_sel_in),
        .ahb_addr_in     (ahb_addr_in),
        .ahb_trans_in    (ahb_trans_in),
        .ahb_burst_in    (ahb_burst_in),
        .ahb_size_in     (ahb_size_in),
        .ahb_write_in    (ahb_write_in),
        .ahb_wdata_in    (ahb_wdata_in),
        .ahb_ready_in    (ahb_ready_in),
        .ahb_ready_out   (ahb_ready_out),
        .ahb_resp_out    (ahb_resp_out),
        .ahb_rdata_out   (ahb_rdata_out),
        .other_valid_out (other_valid_out),
        .other_addr_out  (other_addr_out),
        .other_size_out  (other_size_out),
        .other_write_out (other_write_out),
        .other_wdata_out (other_wdata_out),
`ifdef AHB_SLV_WSTRB_EN
        .other_strb_out  (other_strb_out),
`endif
        .other_ready_in  (other_ready_in),
        .other_error_in  (other_error_in),
        .other_rdata_in  (other_rdata_in)
    );

    task automatic step();
        @(posedge ahb_clk_in);
        #1;
    endtask

    task automatic drive_addr(input logic [1:0] trans, input logic [31:0] addr,
                              input logic [2:0] size, input logic write);
        ahb_sel_in   = 1'b1;
        ahb_trans_in = trans;
        ahb_addr_in  = addr;
        ahb_size_in  = size;
        ahb_write_in = write;
    endtask

    task automatic drive_bus_idle();
        ahb_sel_in   = 1'b0;
        ahb_trans_in = HTRANS_IDLE;
        ahb_addr_in  = '0;
        ahb_size_in  = 3'd0;
        ahb_write_in = 1'b0;
    endtask

    task automatic test_reset();
        ahb_rst_in     = 1'b1;
        drive_bus_idle();
        ahb_burst_in   = HBURST_SINGLE;
        ahb_wdata_in   = '0;
        other_ready_in = 1'b1;
        other_error_in = 1'b0;
        other_rdata_in = 32'hFFFF_FFFF;
        step();
        step();
        @(negedge ahb_clk_in);
        testsRun++;
        if (ahb_ready_out !== 1'b1 || ahb_resp_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ready_resp: got %b/%b expected 1/0", ahb_ready_out, ahb_resp_out);
        end
        testsRun++;
        if (other_valid_out !== 1'b0 || ahb_rdata_out !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_valid_rdata: got %b/%h expected 0/00000000", other_valid_out, ahb_rdata_out);
        end
        testsRun++;
        if (other_addr_out !== 32'h0 || other_size_out !== 3'd0 || other_write_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_capture: got %h/%0d/%b expected 0/0/0", other_addr_out, other_size_out, other_write_out);
        end
        step();
        ahb_rst_in     = 1'b0;
        other_rdata_in = 32'h0;
    endtask

    task automatic test_write();
        step();
        drive_addr(HTRANS_NONSEQ, 32'h100, 3'd2, 1'b1);
        other_ready_in = 1'b1;
        other_rdata_in = 32'hA5A5_A5A5;
        sbQ.push_back('{addr: 32'h100, write: 1'b1, data: 32'hDEAD_BEEF});
        @(negedge ahb_clk_in);
        testsRun++;
        if (other_valid_out !== 1'b0 || ahb_ready_out !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL write_addr_phase: valid/ready got %b/%b expected 0/1", other_valid_out, ahb_ready_out);
        end
        step();
        drive_bus_idle();
        ahb_wdata_in = 32'hDEAD_BEEF;
        @(negedge ahb_clk_in);
        testsRun++;
        if (other_valid_out !== 1'b1 || ahb_ready_out !== 1'b1 || ahb_resp_out !== 1'b0 || ahb_rdata_out !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL write_data_phase: valid/ready/resp/rdata got %b/%b/%b/%h expected 1/1/0/00000000",
                     other_valid_out, ahb_ready_out, ahb_resp_out, ahb_rdata_out);
        end
        testsRun++;
        if (sbQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL write_sb: got empty scoreboard expected one entry");
        end else begin
            exp = sbQ.pop_front();
            if (other_addr_out !== exp.addr || other_write_out !== exp.write || other_wdata_out !== exp.data) begin
                testsFailed++;
                $display("[TB] FAIL write_sb: got %h/%b/%h expected %h/%b/%h", other_addr_out, other_write_out,
                         other_wdata_out, exp.addr, exp.write, exp.data);
            end
        end
        step();
        @(negedge ahb_clk_in);
        testsRun++;
        if (other_valid_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL write_one_cycle: valid got %b expected 0", other_valid_out);
        end
    endtask

    task automatic test_read_wait();
        step();
        drive_addr(HTRANS_NONSEQ, 32'h200, 3'd2, 1'b0);
        other_ready_in = 1'b0;
        sbQ.push_back('{addr: 32'h200, write: 1'b0, data: 32'h1234_5678});
        step();
        drive_bus_idle();
        other_rdata_in = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            @(negedge ahb_clk_in);
            testsRun++;
            if (ahb_ready_out !== 1'b0 || other_valid_out !== 1'b1 || ahb_rdata_out !== 32'h0) begin
                testsFailed++;
                $display("[TB] FAIL read_wait%0d: ready/valid/rdata got %b/%b/%h expected 0/1/00000000",
                         i, ahb_ready_out, other_valid_out, ahb_rdata_out);
            end
            step();
        end
        other_ready_in = 1'b1;
        @(negedge ahb_clk_in);
        testsRun++;
        if (sbQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL read_sb: got empty scoreboard expected one entry");
        end else begin
            exp = sbQ.pop_front();
            if (ahb_ready_out !== 1'b1 || other_addr_out !== exp.addr || other_write_out !== exp.write ||
                ahb_rdata_out !== exp.data) begin
                testsFailed++;
                $display("[TB] FAIL read_sb: ready/addr/write/rdata got %b/%h/%b/%h expected 1/%h/%b/%h", ahb_ready_out,
                         other_addr_out, other_write_out, ahb_rdata_out, exp.addr, exp.write, exp.data);
            end
        end
        step();
        @(negedge ahb_clk_in);
        testsRun++;
        if (ahb_rdata_out !== 32'h0 || other_valid_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL read_after: rdata/valid got %h/%b expected 00000000/0", ahb_rdata_out, other_valid_out);
        end
    endtask

    task automatic test_illegal();
        other_ready_in = 1'b1;
        // Misaligned halfword, then an oversize doubleword on a 32-bit bus.
        for (int k = 0; k < 2; k++) begin
            step();
            if (k == 0) drive_addr(HTRANS_NONSEQ, 32'h101, 3'd1, 1'b1);
            else        drive_addr(HTRANS_NONSEQ, 32'h108, 3'd3, 1'b0);
            step();
            drive_bus_idle();
            @(negedge ahb_clk_in);
            testsRun++;
            if (other_valid_out !== 1'b0 || ahb_ready_out !== 1'b0 || ahb_resp_out !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL illegal%0d_err1: valid/ready/resp got %b/%b/%b expected 0/0/1",
                         k, other_valid_out, ahb_ready_out, ahb_resp_out);
            end
            step();
            @(negedge ahb_clk_in);
            testsRun++;
            if (other_valid_out !== 1'b0 || ahb_ready_out !== 1'b1 || ahb_resp_out !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL illegal%0d_err2: valid/ready/resp got %b/%b/%b expected 0/1/1",
                         k, other_valid_out, ahb_ready_out, ahb_resp_out);
            end
            step();
            @(negedge ahb_clk_in);
            testsRun++;
            if (ahb_ready_out !== 1'b1 || ahb_resp_out !== 1'b0 || other_valid_out !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL illegal%0d_idle: ready/resp/valid got %b/%b/%b expected 1/0/0",
                         k, ahb_ready_out, ahb_resp_out, other_valid_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        other_ready_in = 1'b1;
        step();
        drive_addr(HTRANS_NONSEQ, 32'h0, 3'd2, 1'b0);
        sbQ.push_back('{addr: 32'h0, write: 1'b0, data: 32'h1111_1111});
        step();
        drive_addr(HTRANS_SEQ, 32'h4, 3'd2, 1'b0);
        sbQ.push_back('{addr: 32'h4, write: 1'b0, data: 32'h2222_2222});
        other_rdata_in = 32'h1111_1111;
        for (int i = 0; i < 2; i++) begin
            @(negedge ahb_clk_in);
            testsRun++;
            if (sbQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL b2b_sb%0d: got empty scoreboard expected one entry", i);
            end else begin
                exp = sbQ.pop_front();
                if (other_valid_out !== 1'b1 || other_addr_out !== exp.addr || ahb_rdata_out !== exp.data) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_sb%0d: valid/addr/rdata got %b/%h/%h expected 1/%h/%h",
                             i, other_valid_out, other_addr_out, ahb_rdata_out, exp.addr, exp.data);
                end
            end
            step();
            drive_bus_idle();
            other_rdata_in = 32'h2222_2222;
        end
        @(negedge ahb_clk_in);
        testsRun++;
        if (other_valid_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_end: valid got %b expected 0", other_valid_out);
        end
        other_rdata_in = 32'h0;
    endtask

    task automatic test_busy_idle();
        step();
        drive_addr(HTRANS_BUSY, 32'h500, 3'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge ahb_clk_in);
            testsRun++;
            if (other_valid_out !== 1'b0 || ahb_ready_out !== 1'b1 || ahb_resp_out !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL busy_idle%0d: valid/ready/resp got %b/%b/%b expected 0/1/0",
                         i, other_valid_out, ahb_ready_out, ahb_resp_out);
            end
            step();
            ahb_trans_in = HTRANS_IDLE;
        end
        drive_bus_idle();
    endtask

    task automatic test_backend_error();
        other_ready_in = 1'b1;
        other_error_in = 1'b1;
        step();
        drive_addr(HTRANS_NONSEQ, 32'h300, 3'd2, 1'b0);
        step();
        // Master holds the next address phase through the error response.
        drive_addr(HTRANS_NONSEQ, 32'h304, 3'd2, 1'b1);
        @(negedge ahb_clk_in);
        testsRun++;
        if (ahb_ready_out !== 1'b0 || ahb_resp_out !== 1'b1 || other_valid_out !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL berr_first: ready/resp/valid got %b/%b/%b expected 0/1/1",
                     ahb_ready_out, ahb_resp_out, other_valid_out);
        end
        step();
        other_error_in = 1'b0;
        sbQ.push_back('{addr: 32'h304, write: 1'b1, data: 32'hCAFE_F00D});
        @(negedge ahb_clk_in);
        testsRun++;
        if (ahb_ready_out !== 1'b1 || ahb_resp_out !== 1'b1 || other_valid_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL berr_second: ready/resp/valid got %b/%b/%b expected 1/1/0",
                     ahb_ready_out, ahb_resp_out, other_valid_out);
        end
        step();
        drive_bus_idle();
        ahb_wdata_in = 32'hCAFE_F00D;
        @(negedge ahb_clk_in);
        testsRun++;
        if (sbQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL berr_next_sb: got empty scoreboard expected one entry");
        end else begin
            exp = sbQ.pop_front();
            if (other_valid_out !== 1'b1 || ahb_resp_out !== 1'b0 || other_addr_out !== exp.addr ||
                other_write_out !== exp.write || other_wdata_out !== exp.data) begin
                testsFailed++;
                $display("[TB] FAIL berr_next_sb: valid/resp/addr/write/wdata got %b/%b/%h/%b/%h expected 1/0/%h/%b/%h",
                         other_valid_out, ahb_resp_out, other_addr_out, other_write_out, other_wdata_out,
                         exp.addr, exp.write, exp.data);
            end
        end
        step();
    endtask

    task automatic test_reset_in_wait();
        other_ready_in = 1'b0;
        step();
        drive_addr(HTRANS_NONSEQ, 32'h400, 3'd2, 1'b0);
        step();
        drive_bus_idle();
        @(negedge ahb_clk_in);
        testsRun++;
        if (ahb_ready_out !== 1'b0 || other_valid_out !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rstwait_wait: ready/valid got %b/%b expected 0/1", ahb_ready_out, other_valid_out);
        end
        step();
        ahb_rst_in     = 1'b1;
        other_ready_in = 1'b1;
        other_rdata_in = 32'h7777_7777;
        @(negedge ahb_clk_in);
        testsRun++;
        if (other_valid_out !== 1'b0 || ahb_ready_out !== 1'b1 || ahb_rdata_out !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL rstwait_during: valid/ready/rdata got %b/%b/%h expected 0/1/00000000",
                     other_valid_out, ahb_ready_out, ahb_rdata_out);
        end
        step();
        ahb_rst_in     = 1'b0;
        other_ready_in = 1'b0;
        @(negedge ahb_clk_in);
        testsRun++;
        if (ahb_ready_out !== 1'b1 || other_valid_out !== 1'b0 || other_addr_out !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL rstwait_after: ready/valid/addr got %b/%b/%h expected 1/0/00000000",
                     ahb_ready_out, other_valid_out, other_addr_out);
        end
        other_rdata_in = 32'h0;
    endtask

    task automatic test_byte_lanes();
        other_ready_in = 1'b1;
        step();
        drive_addr(HTRANS_NONSEQ, 32'h3, 3'd0, 1'b1);
        step();
        drive_addr(HTRANS_NONSEQ, 32'h2, 3'd1, 1'b1);
        ahb_wdata_in = 32'h4400_0000;
        @(negedge ahb_clk_in);
        testsRun++;
        if (other_valid_out !== 1'b1 || other_addr_out !== 32'h3 || other_size_out !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL byte_beat: valid/addr/size got %b/%h/%0d expected 1/00000003/0",
                     other_valid_out, other_addr_out, other_size_out);
        end
`ifdef AHB_SLV_WSTRB_EN
        testsRun++;
        if (other_strb_out !== 4'b1000) begin
            testsFailed++;
            $display("[TB] FAIL byte_strb: got %b expected 1000", other_strb_out);
        end
`endif
        step();
        drive_bus_idle();
        @(negedge ahb_clk_in);
        testsRun++;
        if (other_valid_out !== 1'b1 || other_addr_out !== 32'h2 || other_size_out !== 3'd1) begin
            testsFailed++;
            $display("[TB] FAIL half_beat: valid/addr/size got %b/%h/%0d expected 1/00000002/1",
                     other_valid_out, other_addr_out, other_size_out);
        end
`ifdef AHB_SLV_WSTRB_EN
        testsRun++;
        if (other_strb_out !== 4'b1100) begin
            testsFailed++;
            $display("[TB] FAIL half_strb: got %b expected 1100", other_strb_out);
        end
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_illegal();
        test_back_to_back();
        test_busy_idle();
        test_backend_error();
        test_reset_in_wait();
        test_byte_lanes();
        testsRun++;
        if (sbQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL sb_drained: got %0d leftover entries expected 0", sbQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
